// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, an
// auxiliary (mul/div) result waits in a one-entry buffer with starvation stall.
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CW           = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    input  logic        aux_valid,
    input  logic [4:0]  aux_rd,
    input  logic [63:0] aux_data,
    output logic        aux_ready,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        stall_req,
    output logic        buf_valid,
    output logic [4:0]  buf_rd
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        STALL
    } state_e;

    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    state_e        state_q, state_d;
    logic [4:0]    buf_rd_q, buf_rd_d;
    logic [63:0]   buf_data_q, buf_data_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic pipe_claim;
    logic buf_hit;
    logic accept;

    // x0 writes never occupy the port
    assign pipe_claim = !rst && wb_we && (wb_rd != 5'd0);
    assign buf_hit    = pipe_claim && (wb_rd == buf_rd_q);
    assign aux_ready  = (state_q == IDLE) && !rst;
    assign accept     = aux_valid && aux_ready;
    assign buf_valid  = (state_q != IDLE);
    assign buf_rd     = buf_rd_q;
    assign stall_req  = (state_q == STALL);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 64'd0;
        if (pipe_claim) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (buf_valid && !rst) begin
            rf_we    = 1'b1;
            rf_waddr = buf_rd_q;
            rf_wdata = buf_data_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && (aux_rd != 5'd0)) begin
                    state_d    = HOLD;
                    buf_rd_d   = aux_rd;
                    buf_data_d = aux_data;
                    cnt_d      = '0;
                end
            end
            HOLD, STALL: begin
                // Drained this cycle, or superseded by a younger write to the same rd
                if (!pipe_claim || buf_hit) begin
                    state_d    = IDLE;
                    buf_rd_d   = 5'd0;
                    buf_data_d = 64'd0;
                    cnt_d      = '0;
                end else begin
                    if (cnt_q != LIMIT) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (cnt_d == LIMIT) begin
                        state_d = STALL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            buf_rd_q   <= 5'd0;
            buf_data_q <= 64'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Arbitrates the single register-file write port between the in-order pipeline's writeback stage (output of the MEM/WB register, after the mem/ALU result mux) and a long-latency auxiliary unit (multiply/divide). Pipeline writebacks always have priority and are never delayed. Auxiliary results are held in a one-entry buffer until the port is free. A starvation counter requests a one-cycle upstream stall so a buffered result cannot wait indefinitely.

## Interface
Parameters:
- STARVE_LIMIT, 4: number of consecutive blocked HOLD cycles before a stall is requested (1..15).
- CW, 4: width of the starvation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wb_we  in  1  pipeline writeback enable (RegWrite bit of the MEM/WB control field).
- wb_rd  in  5  pipeline destination register.
- wb_data  in  64  pipeline writeback data (already muxed).
- aux_valid  in  1  auxiliary result valid.
- aux_rd  in  5  auxiliary destination register.
- aux_data  in  64  auxiliary result.
- aux_ready  out  1  arbiter can accept an auxiliary result.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  64  register-file write data.
- stall_req  out  1  request to freeze the stages upstream of MEM/WB for bubble insertion.
- buf_valid  out  1  buffered auxiliary result pending (for the hazard unit).
- buf_rd  out  5  destination of the pending result (for the hazard unit).

## Operation
- State machine, reset state IDLE:
  - IDLE: buffer empty.
  - HOLD: buffer full, waiting for a free port.
  - STALL: buffer full, stall_req asserted.
- Port use:
  - The pipeline claims the port when wb_we=1 and wb_rd!=0.
  - Pipeline writes with rd=0 are suppressed. rf_we stays 0 and the port counts as free.
- Write mux (combinational):
  - If the pipeline claims the port: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
  - Else if buf_valid: rf_we=1, rf_waddr=buf_rd, rf_wdata=buffer data. The buffer empties at the next edge.
  - Else: rf_we=0, rf_waddr=0, rf_wdata=0.
- aux_ready = (state==IDLE) && !rst.
  - A transfer occurs on an edge where aux_valid && aux_ready.
  - IDLE → HOLD. The buffer loads aux_rd/aux_data and the counter clears.
  - If aux_rd==0, the result is accepted and discarded; state stays IDLE.
- A buffered result is never written in the cycle it is accepted. Minimum accept-to-write latency is 1 cycle.
- HOLD:
  - Port free: write the buffer → IDLE.
  - Port claimed: counter increments. When the counter reaches STARVE_LIMIT → STALL.
- STALL:
  - stall_req=1 (decoded from registered state).
  - On the first cycle the port is free: write the buffer → IDLE, and stall_req drops at that edge.
- WAW rule, in HOLD or STALL:
  - If the pipeline writes a nonzero wb_rd equal to buf_rd, the buffered entry is dropped at that edge (the younger write wins).
  - Next state is IDLE and the counter clears.
- buf_valid = (state != IDLE). buf_rd holds the buffered rd; it is 0 when empty.

## Timing
- Reset values: state IDLE, buffer data 0, buf_rd 0, counter 0, stall_req 0, buf_valid 0, rf_we 0, rf_waddr 0, rf_wdata 0, aux_ready 0 while rst=1 and 1 after rst deasserts.
- Reset asserted mid-HOLD or mid-STALL discards the buffered result with no write. Pipeline inputs are ignored during reset (rf_we=0).
- Pipeline path latency is 0 cycles (combinational pass-through).
- Auxiliary path:
  - 1 cycle after acceptance if the port is free.
  - Worst case STARVE_LIMIT+1 cycles plus the cycles until the bubble arrives.
- Upstream stages must produce wb_we=0 within 2 cycles of stall_req rising. The arbiter does not depend on the exact bubble timing.
- Counter saturates at STARVE_LIMIT and does not wrap.
- Simultaneous events in one cycle:
  - Pipeline claims the port in IDLE while aux is accepted: both proceed.
  - Buffer drains while aux_valid=1: aux_ready is 0 in that cycle, so acceptance happens the following cycle at the earliest.

## Test plan
- Reset: hold rst 3 cycles with wb_we=1, wb_rd=5 → rf_we=0 and aux_ready=0 throughout. The cycle after release, aux_ready=1 and all other outputs are 0.
- Idle drain: accept aux rd=7 data=0xABCD with pipeline idle → next cycle rf_we=1, rf_waddr=7, rf_wdata=0xABCD, buf_valid=1. The following cycle buf_valid=0 and aux_ready=1.
- Priority: accept aux rd=3, pipeline writes rd=9 for 2 cycles then idles → port shows rd 9 twice, then rd 3. stall_req stays 0.
- Starvation (STARVE_LIMIT=4): accept aux rd=4, pipeline writes continuously (rd=10) → after 4 blocked HOLD cycles stall_req=1. Drop wb_we → rd 4 is written that cycle and stall_req=0 the next cycle.
- WAW: buffer holds rd=6, pipeline writes rd=6 data=0x11 → rf_wdata=0x11. The buffer is dropped (buf_valid=0 next cycle) and x6 is never written with the aux data.
- x0 and reset mid-op: aux rd=0 is accepted with no write and state stays IDLE. Pipeline rd=0 with wb_we=1 frees the port so a buffered rd=2 is written. rst asserted in STALL → next cycle stall_req=0, buf_valid=0, no write.
